// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime-selectable parity and stop bits, configurable oversampling
// and 3-sample majority voting per bit. Good frames are reported with a one-cycle RX_Valid.
module uart_rx_cfg #(
   parameter int DATA_W      = 8,
   parameter int PRESCALE_W  = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  UART_CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic [DATA_W-1:0]     P_Data,
   output logic                  RX_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err,
   output logic                  Busy
);

   localparam int BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                  state, next_state;
   logic [SYNC_STAGES-1:0]  sync_ff;
   logic                    rx_s, rx_d;
   logic [PRESCALE_W-1:0]   p_lat, half, edge_cnt;
   logic [BIT_W-1:0]        bit_cnt;
   logic                    par_en_l, par_typ_l, stop2_l;
   logic                    samp0, samp1, maj;
   logic [DATA_W-1:0]       shift_reg;
   logic                    par_bad, stop_bad;
   logic                    start_edge, at_s0, at_s1, at_dec, at_end;
   logic                    last_data, last_stop, frame_done;

   assign rx_s       = sync_ff[SYNC_STAGES-1];
   assign start_edge = rx_d && !rx_s;
   assign half       = p_lat >> 1;
   assign at_s0      = (edge_cnt == half - PRESCALE_W'(1));
   assign at_s1      = (edge_cnt == half);
   assign at_dec     = (edge_cnt == half + PRESCALE_W'(1));
   assign at_end     = (edge_cnt == p_lat - PRESCALE_W'(1));
   assign maj        = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
   assign last_data  = (bit_cnt == BIT_W'(DATA_W - 1));
   assign last_stop  = (bit_cnt == (stop2_l ? BIT_W'(1) : BIT_W'(0)));
   assign Busy       = (state != IDLE);

   always_ff @(posedge UART_CLK) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   // Frame sequencing; a start bit whose majority reads high is treated as a glitch.
   always_comb begin
      next_state = state;
      frame_done = 1'b0;
      case (state)
         IDLE:    if (start_edge) next_state = START;
         START: begin
            if (at_dec && maj) next_state = IDLE;
            else if (at_end)   next_state = DATA;
         end
         DATA:    if (at_end && last_data) next_state = par_en_l ? PARITY : STOP;
         PARITY:  if (at_end) next_state = STOP;
         STOP: begin
            if (at_dec && last_stop) begin
               next_state = IDLE;
               frame_done = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge UART_CLK) begin
      if (RST) begin
         sync_ff   <= '1;
         rx_d      <= 1'b1;
         edge_cnt  <= '0;
         bit_cnt   <= '0;
         p_lat     <= PRESCALE_W'(4);
         par_en_l  <= 1'b0;
         par_typ_l <= 1'b0;
         stop2_l   <= 1'b0;
         samp0     <= 1'b0;
         samp1     <= 1'b0;
         shift_reg <= '0;
         par_bad   <= 1'b0;
         stop_bad  <= 1'b0;
         P_Data    <= '0;
         RX_Valid  <= 1'b0;
         Par_Err   <= 1'b0;
         Stp_Err   <= 1'b0;
      end else begin
         sync_ff  <= {sync_ff[SYNC_STAGES-2:0], RX_IN};
         rx_d     <= rx_s;
         RX_Valid <= 1'b0;
         Par_Err  <= 1'b0;
         Stp_Err  <= 1'b0;

         if (state == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            // Configuration is frozen for the whole frame at the start edge.
            if (start_edge) begin
               p_lat     <= (Prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : Prescale;
               par_en_l  <= PAR_EN;
               par_typ_l <= PAR_TYP;
               stop2_l   <= STOP2;
            end
         end else begin
            edge_cnt <= at_end ? '0 : edge_cnt + PRESCALE_W'(1);
            if (at_s0) samp0 <= rx_s;
            if (at_s1) samp1 <= rx_s;
            if (at_end && state == DATA) bit_cnt <= last_data ? '0 : bit_cnt + BIT_W'(1);
            if (at_end && state == STOP) bit_cnt <= bit_cnt + BIT_W'(1);
            if (at_dec) begin
               case (state)
                  DATA:    shift_reg <= {maj, shift_reg[DATA_W-1:1]};
                  PARITY:  par_bad   <= (maj != (par_typ_l ? ~^shift_reg : ^shift_reg));
                  STOP:    if (!maj) stop_bad <= 1'b1;
                  default: ;
               endcase
            end
         end

         // The final stop bit's vote is folded in here since it is not yet in stop_bad.
         if (frame_done) begin
            if (!par_bad && !stop_bad && maj) begin
               RX_Valid <= 1'b1;
               P_Data   <= shift_reg;
            end else begin
               Par_Err <= par_bad;
               Stp_Err <= stop_bad | !maj;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames,
// compared against a frame-level model of expected strobes, data and timing.
module tb_uart_rx_cfg;

   logic       UART_CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN, PAR_TYP, STOP2;
   logic [7:0] P_Data;
   logic       RX_Valid, Par_Err, Stp_Err, Busy;

   typedef struct {
      bit         v;
      bit         pe;
      bit         se;
      logic [7:0] d;
      int         c;
   } ev_t;

   ev_t        ev_q[$];
   ev_t        exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         busy_low = 0;
   int         fall;
   int         gap;
   logic [7:0] model_data;

   uart_rx_cfg #(.DATA_W(8), .PRESCALE_W(6), .SYNC_STAGES(2)) dut (
      .UART_CLK (UART_CLK),
      .RST      (RST),
      .RX_IN    (RX_IN),
      .Prescale (Prescale),
      .PAR_EN   (PAR_EN),
      .PAR_TYP  (PAR_TYP),
      .STOP2    (STOP2),
      .P_Data   (P_Data),
      .RX_Valid (RX_Valid),
      .Par_Err  (Par_Err),
      .Stp_Err  (Stp_Err),
      .Busy     (Busy)
   );

   always #5 UART_CLK = ~UART_CLK;

   always @(posedge UART_CLK) cyc++;

   always @(negedge UART_CLK) begin : monitor
      ev_t e;
      if (RX_Valid || Par_Err || Stp_Err) begin
         e.v  = RX_Valid;
         e.pe = Par_Err;
         e.se = Stp_Err;
         e.d  = P_Data;
         e.c  = cyc;
         ev_q.push_back(e);
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge UART_CLK);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int frame_latency(input int n_bits, input int p);
      return 2 + (n_bits - 1) * p + p / 2 + 3;
   endfunction

   // Drives one frame on RX_IN and records what the receiver should report for it.
   task automatic applyStimulus(input logic [7:0] data, input int p_cfg, input bit pen,
                                input bit ptyp, input bit st2, input bit flip_par,
                                input int bad_stop, input bit scramble);
      bit  bits[$];
      int  p, fall_l, lat, el;
      bit  par_ok, stop_ok;
      ev_t e;
      p        = (p_cfg < 4) ? 4 : p_cfg;
      Prescale = 6'(p_cfg);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      STOP2    = st2;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (pen) bits.push_back(($countones(data) % 2 == 1) ^ ptyp ^ flip_par);
      bits.push_back(bad_stop != 1);
      if (st2) bits.push_back(bad_stop != 2);
      par_ok  = !(pen && flip_par);
      stop_ok = (bad_stop == 0);
      fall_l  = cyc;
      lat     = frame_latency(bits.size(), p);
      e.v     = par_ok && stop_ok;
      e.pe    = !par_ok;
      e.se    = !stop_ok;
      e.d     = data;
      e.c     = fall_l + lat;
      exp_q.push_back(e);
      if (e.v) model_data = data;
      for (int b = 0; b < bits.size(); b++) begin
         for (int k = 0; k < p; k++) begin
            RX_IN = bits[b];
            if (scramble && b == 3 && k == 0) begin
               Prescale = 6'($urandom_range(0, 63));
               PAR_EN   = 1'($urandom_range(0, 1));
               PAR_TYP  = 1'($urandom_range(0, 1));
               STOP2    = 1'($urandom_range(0, 1));
            end
            el = cyc - fall_l;
            if (el >= 3 && el < lat && Busy !== 1'b1) busy_low++;
            @(negedge UART_CLK);
         end
      end
      RX_IN = 1'b1;
   endtask

   task automatic check_events(input string tag);
      checkOutput({tag, " count"}, ev_q.size(), exp_q.size());
      for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
         checkOutput({tag, " flags"}, {ev_q[i].v, ev_q[i].pe, ev_q[i].se},
                     {exp_q[i].v, exp_q[i].pe, exp_q[i].se});
         checkOutput({tag, " cycle"}, ev_q[i].c, exp_q[i].c);
         if (exp_q[i].v) checkOutput({tag, " data"}, ev_q[i].d, exp_q[i].d);
      end
      checkOutput({tag, " P_Data"}, P_Data, model_data);
      ev_q.delete();
      exp_q.delete();
   endtask

   initial begin
      ev_t e;
      RST        = 1'b1;
      RX_IN      = 1'b1;
      Prescale   = 6'd8;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      STOP2      = 1'b0;
      model_data = 8'h00;
      wait_cycles(3);
      checkOutput("reset outputs", {P_Data, RX_Valid, Par_Err, Stp_Err, Busy}, 32'h0);
      RST = 1'b0;
      wait_cycles(4);

      busy_low = 0;
      applyStimulus(8'hA5, 8, 0, 0, 0, 0, 0, 0);
      wait_cycles(16);
      checkOutput("8N1 busy", busy_low, 0);
      check_events("8N1 A5");

      applyStimulus(8'h03, 8, 1, 0, 0, 1, 0, 0);
      wait_cycles(16);
      check_events("even parity error");

      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      STOP2    = 1'b0;
      fall     = cyc;
      RX_IN    = 1'b0;
      wait_cycles(2);
      RX_IN = 1'b1;
      wait_cycles(3);
      checkOutput("glitch busy@5", Busy, 1'b1);
      wait_cycles(4);
      checkOutput("glitch busy@9", Busy, 1'b0);
      wait_cycles(16);
      check_events("glitch");
      applyStimulus(8'h96, 8, 0, 0, 0, 0, 0, 0);
      wait_cycles(16);
      check_events("after glitch");

      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      STOP2    = 1'b0;
      fall     = cyc;
      RX_IN    = 1'b0;
      e.v  = 1'b0;
      e.pe = 1'b0;
      e.se = 1'b1;
      e.d  = 8'h00;
      e.c  = fall + frame_latency(10, 8);
      exp_q.push_back(e);
      wait_cycles(320);
      checkOutput("break busy", Busy, 1'b0);
      RX_IN = 1'b1;
      wait_cycles(16);
      check_events("break");
      applyStimulus(8'h5A, 8, 0, 0, 0, 0, 0, 0);
      wait_cycles(16);
      check_events("after break");

      applyStimulus(8'h00, 16, 0, 0, 1, 0, 0, 0);
      applyStimulus(8'hFF, 16, 0, 0, 1, 0, 0, 0);
      wait_cycles(48);
      checkOutput("b2b spacing", (ev_q.size() >= 2) ? ev_q[1].c - ev_q[0].c : -1, 176);
      check_events("b2b");

      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      STOP2    = 1'b0;
      RX_IN    = 1'b0;
      wait_cycles(8);
      RX_IN = 1'b1;
      wait_cycles(8);
      RX_IN = 1'b0;
      wait_cycles(8);
      RX_IN = 1'b1;
      wait_cycles(4);
      RST   = 1'b1;
      RX_IN = 1'b1;
      wait_cycles(1);
      checkOutput("mid reset outputs", {P_Data, RX_Valid, Par_Err, Stp_Err, Busy}, 32'h0);
      wait_cycles(2);
      checkOutput("mid reset hold", {P_Data, RX_Valid, Par_Err, Stp_Err, Busy}, 32'h0);
      RST        = 1'b0;
      model_data = 8'h00;
      wait_cycles(16);
      check_events("aborted frame");
      applyStimulus(8'h3C, 8, 0, 0, 0, 0, 0, 0);
      wait_cycles(16);
      check_events("after reset");

      busy_low = 0;
      for (int i = 0; i < 12; i++) begin
         int         p_cfg, bstop;
         bit         pen, ptyp, st2, flip;
         logic [7:0] d;
         d     = 8'($urandom_range(0, 255));
         p_cfg = $urandom_range(3, 20);
         pen   = 1'($urandom_range(0, 1));
         ptyp  = 1'($urandom_range(0, 1));
         st2   = 1'($urandom_range(0, 1));
         flip  = pen && ($urandom_range(0, 3) == 0);
         bstop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, st2 ? 2 : 1) : 0;
         applyStimulus(d, p_cfg, pen, ptyp, st2, flip, bstop, 1);
         gap = 3 * ((p_cfg < 4) ? 4 : p_cfg);
         wait_cycles(gap);
         check_events("random frame");
      end
      checkOutput("random busy", busy_low, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
